// File: rtl/instruction_fetch_unit_if.sv
// Fetch-stage bus bundle: hazard/decode controls, ROM data in, IF/ID and PC out.
// master: the surroundings (hazard unit, decode, ROM); slave: the fetch unit.
interface instruction_fetch_unit_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  Stall;
  logic                  BranchTaken;
  logic [15:0]           BranchOffset;
  logic                  Jump;
  logic [25:0]           JumpIndex;
  logic                  JumpReg;
  logic [DATA_WIDTH-1:0] JumpRegTarget;
  logic [DATA_WIDTH-1:0] Instruction;
  logic [DATA_WIDTH-1:0] PC;
  logic [DATA_WIDTH-1:0] IFID_Instruction;
  logic [DATA_WIDTH-1:0] IFID_PCPlus4;
  logic                  IFID_Valid;
  logic                  AddrError;

  modport master (
    output Stall, BranchTaken, BranchOffset, Jump, JumpIndex, JumpReg,
           JumpRegTarget, Instruction,
    input  PC, IFID_Instruction, IFID_PCPlus4, IFID_Valid, AddrError
  );

  modport slave (
    input  Stall, BranchTaken, BranchOffset, Jump, JumpIndex, JumpReg,
           JumpRegTarget, Instruction,
    output PC, IFID_Instruction, IFID_PCPlus4, IFID_Valid, AddrError
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: owns the PC, drives it to the program ROM and
// latches the returned word into the IF/ID register. Next PC is PC+4 or a
// branch / jump / jump-register redirect from ID (priority JR > J > branch),
// with hazard stall and redirect flush.
// Optional macro FETCH_ALIGN_TRAP_EN: a misaligned JR target raises a sticky
// AddrError and freezes fetch until reset; without it the low target bits are
// silently masked and AddrError is tied low.
module instruction_fetch_unit #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD   = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  instruction_fetch_unit_if.slave  fetch
);

  localparam logic [DATA_WIDTH-1:0] WORD_STEP  = DATA_WIDTH'(4);
  localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = ~DATA_WIDTH'(3);

  logic [DATA_WIDTH-1:0] pc_reg, pc_next;
  logic [DATA_WIDTH-1:0] ifid_instr_reg, ifid_instr_next;
  logic [DATA_WIDTH-1:0] ifid_pcplus4_reg, ifid_pcplus4_next;
  logic                  ifid_valid_reg, ifid_valid_next;

  logic [DATA_WIDTH-1:0] pc_plus4;
  logic [DATA_WIDTH-1:0] branch_disp;
  logic [DATA_WIDTH-1:0] branch_target;
  logic [DATA_WIDTH-1:0] jump_target;
  logic [DATA_WIDTH-1:0] jr_target;
  logic [DATA_WIDTH-1:0] redirect_target;
  logic                  redirect;

  // Sign-extended word offset shifted left by two, built bit by bit.
  genvar gi;
  generate
    for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_disp
      if (gi < 2) begin : g_zero
        assign branch_disp[gi] = 1'b0;
      end else if (gi < 18) begin : g_field
        assign branch_disp[gi] = fetch.BranchOffset[gi-2];
      end else begin : g_sign
        assign branch_disp[gi] = fetch.BranchOffset[15];
      end
    end
  endgenerate

  // Targets are relative to the ID-stage instruction, i.e. IFID_PCPlus4.
  assign pc_plus4      = pc_reg + WORD_STEP;
  assign branch_target = ifid_pcplus4_reg + branch_disp;
  assign jump_target   = {ifid_pcplus4_reg[DATA_WIDTH-1:28], fetch.JumpIndex, 2'b00};
`ifdef FETCH_ALIGN_TRAP_EN
  // Aligned targets pass through; misaligned ones never reach the PC.
  assign jr_target     = fetch.JumpRegTarget;
`else
  assign jr_target     = fetch.JumpRegTarget & ALIGN_MASK;
`endif

  // A redirect only counts when ID actually holds a fetched instruction.
  assign redirect = ifid_valid_reg & (fetch.JumpReg | fetch.Jump | fetch.BranchTaken);

  // Target select in priority order JR > J > branch.
  always_comb begin
    redirect_target = branch_target;
    if (fetch.JumpReg) begin
      redirect_target = jr_target;
    end else if (fetch.Jump) begin
      redirect_target = jump_target;
    end
  end

`ifdef FETCH_ALIGN_TRAP_EN
  logic addr_error_reg, addr_error_next;
  logic jr_misaligned;
  assign jr_misaligned = ifid_valid_reg & fetch.JumpReg & (|fetch.JumpRegTarget[1:0]);
`endif

  // Next-state selection: (trap) > redirect > stall > normal sequential fetch.
  always_comb begin
    pc_next           = pc_reg;
    ifid_instr_next   = ifid_instr_reg;
    ifid_pcplus4_next = ifid_pcplus4_reg;
    ifid_valid_next   = ifid_valid_reg;
`ifdef FETCH_ALIGN_TRAP_EN
    addr_error_next   = addr_error_reg;
    if (addr_error_reg) begin
      ifid_instr_next = NOP_WORD;
      ifid_valid_next = 1'b0;
    end else if (jr_misaligned) begin
      ifid_instr_next = NOP_WORD;
      ifid_valid_next = 1'b0;
      addr_error_next = 1'b1;
    end else
`endif
    if (redirect) begin
      // The stalled slot is the one being flushed, so redirect beats stall.
      pc_next         = redirect_target;
      ifid_instr_next = NOP_WORD;
      ifid_valid_next = 1'b0;
    end else if (!fetch.Stall) begin
      pc_next           = pc_plus4;
      ifid_instr_next   = fetch.Instruction;
      ifid_pcplus4_next = pc_plus4;
      ifid_valid_next   = 1'b1;
    end
  end

  // PC and IF/ID pipeline register, reset to the boot address and a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_reg           <= RESET_PC;
      ifid_instr_reg   <= NOP_WORD;
      ifid_pcplus4_reg <= RESET_PC;
      ifid_valid_reg   <= 1'b0;
    end else begin
      pc_reg           <= pc_next;
      ifid_instr_reg   <= ifid_instr_next;
      ifid_pcplus4_reg <= ifid_pcplus4_next;
      ifid_valid_reg   <= ifid_valid_next;
    end
  end

`ifdef FETCH_ALIGN_TRAP_EN
  // Sticky misaligned-JR flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_error_reg <= 1'b0;
    end else begin
      addr_error_reg <= addr_error_next;
    end
  end
  assign fetch.AddrError = addr_error_reg;
`else
  assign fetch.AddrError = 1'b0;
`endif

  assign fetch.PC               = pc_reg;
  assign fetch.IFID_Instruction = ifid_instr_reg;
  assign fetch.IFID_PCPlus4     = ifid_pcplus4_reg;
  assign fetch.IFID_Valid       = ifid_valid_reg;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios followed by random
// stall/redirect/reset traffic, every cycle compared with a behavioural model.
// Build with +define+FETCH_ALIGN_TRAP_EN to cover the alignment-trap variant.
module tb_instruction_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic clk = 1'b0;
  logic reset;

  instruction_fetch_unit_if #(.DATA_WIDTH(32)) bus ();

  instruction_fetch_unit #(
    .DATA_WIDTH (32),
    .RESET_PC   (32'h0000_0000),
    .NOP_WORD   (NOP)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .fetch (bus)
  );

  always #5 clk = ~clk;

  // Program ROM: combinational read of the word addressed by PC.
  logic [31:0] rom [0:63];
  assign bus.Instruction = rom[bus.PC[7:2]];

  int checks = 0;
  int errors = 0;
  int txn    = 0;

  // Architectural state of the reference model.
  logic [31:0] m_pc, m_instr, m_pcp4;
  logic        m_valid, m_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // One clock of the fetch stage as seen from outside.
  task automatic model_edge(input logic rst, input logic st, input logic br,
                            input logic [15:0] off, input logic j,
                            input logic [25:0] idx, input logic jr,
                            input logic [31:0] jrt);
    logic [31:0] tgt;
    logic        trap;
    if (rst) begin
      m_pc = 32'h0; m_instr = NOP; m_pcp4 = 32'h0; m_valid = 1'b0; m_err = 1'b0;
      return;
    end
    if (m_err) begin
      m_instr = NOP; m_valid = 1'b0;
      return;
    end
    if (m_valid && (jr || j || br)) begin
      trap = 1'b0;
      if (jr) begin
`ifdef FETCH_ALIGN_TRAP_EN
        trap = (jrt % 4) != 0;
        tgt  = jrt;
`else
        tgt  = jrt - (jrt % 4);
`endif
      end else if (j) begin
        tgt = (m_pcp4 & 32'hF000_0000) | (32'(idx) * 32'd4);
      end else begin
        tgt = m_pcp4 + 32'($signed(off)) * 32'd4;
      end
      if (trap) m_err = 1'b1;
      else      m_pc  = tgt;
      m_instr = NOP;
      m_valid = 1'b0;
    end else if (!st) begin
      m_instr = rom[m_pc[7:2]];
      m_pcp4  = m_pc + 32'd4;
      m_pc    = m_pcp4;
      m_valid = 1'b1;
    end
  endtask

  task automatic step(input logic rst, input logic st, input logic br,
                      input logic [15:0] off, input logic j,
                      input logic [25:0] idx, input logic jr,
                      input logic [31:0] jrt);
    reset             = rst;
    bus.Stall         = st;
    bus.BranchTaken   = br;
    bus.BranchOffset  = off;
    bus.Jump          = j;
    bus.JumpIndex     = idx;
    bus.JumpReg       = jr;
    bus.JumpRegTarget = jrt;
    model_edge(rst, st, br, off, j, idx, jr, jrt);
    @(posedge clk);
    #1;
    txn++;
    $display("txn %0d: rst=%0b st=%0b br=%0b j=%0b jr=%0b -> pc=%08h ifid=%08h pc4=%08h v=%0b err=%0b",
             txn, rst, st, br, j, jr, bus.PC, bus.IFID_Instruction, bus.IFID_PCPlus4,
             bus.IFID_Valid, bus.AddrError);
    check("pc",           bus.PC,               m_pc);
    check("ifid_instr",   bus.IFID_Instruction, m_instr);
    check("ifid_pcplus4", bus.IFID_PCPlus4,     m_pcp4);
    check("ifid_valid",   32'(bus.IFID_Valid),  32'(m_valid));
    check("addr_error",   32'(bus.AddrError),   32'(m_err));
  endtask

  task automatic idle(input logic st);
    step(1'b0, st, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0);
  endtask

  task automatic random_step(input logic allow_reset);
    logic        rst, st, br, j, jr;
    logic [15:0] off;
    logic [25:0] idx;
    logic [31:0] jrt;
    rst = allow_reset && ($urandom_range(99) < 3);
    st  = ($urandom_range(3) == 0);
    br  = ($urandom_range(7) == 0);
    j   = ($urandom_range(9) == 0);
    jr  = ($urandom_range(9) == 0);
    off = 16'($urandom);
    idx = 26'($urandom);
    jrt = $urandom;
`ifdef FETCH_ALIGN_TRAP_EN
    jrt[1:0] = 2'b00;
`endif
    step(rst, st, br, off, j, idx, jr, jrt);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = $urandom;
    rom[0] = 32'h1111_1111;
    rom[1] = 32'h2222_2222;
    rom[2] = 32'h3333_3333;
    reset = 1'b1;
    bus.Stall = 1'b0; bus.BranchTaken = 1'b0; bus.BranchOffset = '0;
    bus.Jump = 1'b0; bus.JumpIndex = '0; bus.JumpReg = 1'b0; bus.JumpRegTarget = '0;

    // Reset state.
    step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 16'h7, 1'b1, 26'h5, 1'b1, 32'h80);
    check("rst_pc",    bus.PC, 32'h0);
    check("rst_valid", 32'(bus.IFID_Valid), 32'h0);
    check("rst_instr", bus.IFID_Instruction, NOP);

    // Sequential fetch.
    idle(1'b0);
    check("seq_instr0", bus.IFID_Instruction, 32'h1111_1111);
    check("seq_pc4_0",  bus.IFID_PCPlus4, 32'h4);
    idle(1'b0);
    check("seq_instr1", bus.IFID_Instruction, 32'h2222_2222);
    check("seq_pc1",    bus.PC, 32'h8);

    // Three-cycle stall holds everything.
    repeat (3) idle(1'b1);
    check("stall_pc",    bus.PC, 32'h8);
    check("stall_instr", bus.IFID_Instruction, 32'h2222_2222);
    check("stall_pc4",   bus.IFID_PCPlus4, 32'h8);

    // Backward branch from PCPlus4 = 8.
    step(1'b0, 1'b0, 1'b1, 16'hFFFE, 1'b0, 26'h0, 1'b0, 32'h0);
    check("bbr_pc",    bus.PC, 32'h0);
    check("bbr_valid", 32'(bus.IFID_Valid), 32'h0);
    check("bbr_instr", bus.IFID_Instruction, NOP);
    // Branch with an empty IF/ID is ignored.
    step(1'b0, 1'b0, 1'b1, 16'h0003, 1'b0, 26'h0, 1'b0, 32'h0);
    check("qual_pc", bus.PC, 32'h4);
    idle(1'b0);
    // Forward branch from PCPlus4 = 8.
    step(1'b0, 1'b0, 1'b1, 16'h0003, 1'b0, 26'h0, 1'b0, 32'h0);
    check("fbr_pc", bus.PC, 32'd20);

    // Get IFID_PCPlus4 = 0x10, then jump with branch and stall also raised.
    idle(1'b0);
    step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b1, 32'h0000_000C);
    idle(1'b0);
    check("pre_j_pc4", bus.IFID_PCPlus4, 32'h10);
    step(1'b0, 1'b1, 1'b1, 16'h1234, 1'b1, 26'h000_0010, 1'b0, 32'h0);
    check("jmp_pc",    bus.PC, 32'h40);
    check("jmp_valid", 32'(bus.IFID_Valid), 32'h0);

    // PC wrap from the top of the address space.
    idle(1'b0);
    step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b1, 32'hFFFF_FFFC);
    check("wrap_pre", bus.PC, 32'hFFFF_FFFC);
    idle(1'b0);
    check("wrap_pc",  bus.PC, 32'h0);
    check("wrap_pc4", bus.IFID_PCPlus4, 32'h0);

    // Reset in the middle of a stall.
    idle(1'b1);
    step(1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0);
    check("rst_stall_pc",    bus.PC, 32'h0);
    check("rst_stall_valid", 32'(bus.IFID_Valid), 32'h0);

    // Random traffic.
    repeat (300) random_step(1'b1);

    // Misaligned jump-register target.
    step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0);
    idle(1'b0);
    step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b1, 32'h0000_0046);
`ifdef FETCH_ALIGN_TRAP_EN
    check("mis_pc",  bus.PC, 32'h4);
    check("mis_err", 32'(bus.AddrError), 32'h1);
    repeat (6) random_step(1'b0);
    check("frozen_pc",  bus.PC, 32'h4);
    check("frozen_err", 32'(bus.AddrError), 32'h1);
`else
    check("mis_pc",  bus.PC, 32'h44);
    check("mis_err", 32'(bus.AddrError), 32'h0);
    repeat (6) random_step(1'b0);
`endif
    step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0);
    check("clr_err", 32'(bus.AddrError), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Fetch stage directly upstream of the program memory ROM.
- Owns the program counter and drives the PC onto the ROM address input.
- Captures the combinational instruction returned by the ROM into the IF/ID pipeline register.
- Selects the next PC from PC+4, branch, jump or jump-register targets, with stall and flush control from the hazard logic.

Parameters:
- DATA_WIDTH, 32, width of PC, instructions and targets.
- RESET_PC, 32'h00000000, PC value loaded on reset; must be word-aligned.
- NOP_WORD, 32'h00000000, instruction word inserted into IF/ID on reset or flush.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- Stall  input  1  hazard unit request to hold PC and IF/ID.
- BranchTaken  input  1  branch in ID resolved taken.
- BranchOffset  input  16  signed word offset from the ID-stage instruction.
- Jump  input  1  J/JAL in ID.
- JumpIndex  input  26  instr_index field of the ID-stage instruction.
- JumpReg  input  1  JR/JALR in ID.
- JumpRegTarget  input  DATA_WIDTH  register-file value for JR.
- Instruction  input  DATA_WIDTH  combinational ROM output for address PC.
- PC  output  DATA_WIDTH  current fetch address, to ROM Address.
- IFID_Instruction  output  DATA_WIDTH  latched instruction for decode.
- IFID_PCPlus4  output  DATA_WIDTH  PC+4 of the latched instruction.
- IFID_Valid  output  1  IF/ID holds a real fetched instruction.
- AddrError  output  1  misaligned-target flag; only with FETCH_ALIGN_TRAP_EN, otherwise tied 0.

Behaviour:
- Reset values:
  - PC = RESET_PC.
  - IFID_Instruction = NOP_WORD.
  - IFID_PCPlus4 = RESET_PC.
  - IFID_Valid = 0.
  - AddrError = 0.
- Reset wins over all other inputs in the same cycle.
- PCPlus4 = PC + 4, modulo 2^DATA_WIDTH; 32'hFFFFFFFC wraps to 0, no flag.
- Target computation uses IFID_PCPlus4, i.e. the delay-free ID-stage instruction address:
  - BranchTarget = IFID_PCPlus4 + (sign_extend(BranchOffset) << 2), modulo 2^32.
  - JumpTarget = {IFID_PCPlus4[31:28], JumpIndex, 2'b00}.
  - JrTarget = JumpRegTarget.
- Redirect priority: JumpReg > Jump > BranchTaken. Redirect = any of the three asserted.
- Redirects are qualified by IFID_Valid; redirect inputs are ignored when IFID_Valid = 0.
- Per cycle, in priority order:
  - Redirect: PC <- selected target; IF/ID flushed (Instruction = NOP_WORD, Valid = 0, PCPlus4 unchanged).
  - Stall (no redirect): PC, IFID_Instruction, IFID_PCPlus4 and IFID_Valid all hold.
  - Normal: PC <- PCPlus4; IFID_Instruction <- Instruction; IFID_PCPlus4 <- PCPlus4; IFID_Valid <- 1.
- Redirect overrides Stall in the same cycle (stall belongs to the flushed slot).
- Latency:
  - Instruction at address A appears on IFID_Instruction one edge after PC = A with no stall or redirect.
  - Redirect penalty is 1 bubble.
- PC[1:0] is always 00. Without the macro, JrTarget[1:0] is forced to 00.

Optional Feature:
- Macro: FETCH_ALIGN_TRAP_EN.
- Defined:
  - A JR redirect with JumpRegTarget[1:0] != 00 does not load PC; PC holds.
  - IF/ID is flushed.
  - AddrError sets and stays set (sticky) until reset.
  - While AddrError = 1, PC freezes and IFID_Valid stays 0.
- Undefined:
  - Low bits are masked silently.
  - AddrError is constant 0.

Test Plan:
- Reset then release with ROM[0..2] = 11111111, 22222222, 33333333 -> PC steps 0, 4, 8; IFID_Instruction = 11111111 after edge 1, 22222222 after edge 2; IFID_PCPlus4 = 4, 8.
- Stall held 3 cycles at PC = 8 -> PC stays 8, IFID holds 22222222/8 for 3 edges, then resumes to 33333333.
- ID instruction at PCPlus4 = 8, BranchTaken = 1, BranchOffset = 16'hFFFE -> PC = 0, next IFID_Valid = 0 with NOP_WORD; BranchOffset = 16'h0003 -> PC = 20.
- Jump = 1, JumpIndex = 26'h0000010, IFID_PCPlus4 = 32'h00000010, with BranchTaken = 1 and Stall = 1 simultaneously -> PC = 32'h00000040, IF/ID flushed.
- JumpReg = 1, JumpRegTarget = 32'h00000046 -> without macro PC = 0x44, AddrError = 0; with FETCH_ALIGN_TRAP_EN PC holds, AddrError = 1 until reset.
- Force PC = 32'hFFFFFFFC, normal cycle -> PC = 0, IFID_PCPlus4 = 0; reset asserted mid-stall -> PC = RESET_PC, IFID_Valid = 0 next edge.
